// File: rtl/std_fifo_stream_reader_pkg.sv
// Shared constants and buffer-occupancy encoding for the std FIFO stream reader.
package std_fifo_stream_reader_pkg;

    localparam int BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/stream_skid_buf2.sv
// Two-entry head/tail register buffer; push/pop act on the edge, head is the output word.
// No latency through the head register once written; caller guarantees no push when full without pop.
module stream_skid_buf2
    import std_fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [DATA_WIDTH-1:0] i_din,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic [1:0]            o_occ
);

    occ_e                  r_state;
    occ_e                  w_state_nxt;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic [DATA_WIDTH-1:0] w_head_nxt;
    logic [DATA_WIDTH-1:0] w_tail_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= OCC_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        if (i_clear) begin
            w_state_nxt = OCC_EMPTY;
        end else begin
            case (r_state)
                OCC_EMPTY: begin
                    if (i_push) begin
                        w_head_nxt  = i_din;
                        w_state_nxt = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (i_push && !i_pop) begin
                        w_tail_nxt  = i_din;
                        w_state_nxt = OCC_FULL;
                    end else if (i_push && i_pop) begin
                        w_head_nxt  = i_din;
                    end else if (i_pop) begin
                        w_state_nxt = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    // Tail always moves up on a pop; a simultaneous push refills the tail.
                    if (i_pop) begin
                        w_head_nxt = r_tail;
                        if (i_push) begin
                            w_tail_nxt = i_din;
                        end else begin
                            w_state_nxt = OCC_ONE;
                        end
                    end
                end
                default: w_state_nxt = OCC_EMPTY;
            endcase
        end
    end

    assign o_head = r_head;
    assign o_occ  = r_state;

endmodule

// File: rtl/std_fifo_stream_reader.sv
// Drains a non-FWFT BRAM FIFO into a valid/ready stream; 2 edges from read to m_valid, 1 word/cycle.
// Backpressure: reads stop once buffered plus in-flight words reach 2; m_ready feeds fifo_rd_en combinationally.
module std_fifo_stream_reader
    import std_fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            buf_cnt
);

    localparam logic [2:0] BUF_LIMIT = 3'(BUF_DEPTH);

    logic                  r_inflight;
    logic [1:0]            w_occ;
    logic                  w_valid;
    logic                  w_pop;
    logic                  w_push;
    logic [2:0]            w_pending;
    logic [DATA_WIDTH-1:0] w_head;

    assign w_valid   = (w_occ != 2'd0);
    assign w_pop     = w_valid & m_ready;
    assign w_push    = r_inflight & ~flush;
    // Pop only happens with occ >= 1, so the difference never underflows.
    assign w_pending = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

    assign fifo_rd_en = ~rst & ~flush & ~fifo_empty & (w_pending < BUF_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= fifo_rd_en;
        end
    end

    stream_skid_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_clear (flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (fifo_dout),
        .o_head  (w_head),
        .o_occ   (w_occ)
    );

    assign m_valid = w_valid;
    assign m_data  = w_head;
    assign buf_cnt = w_occ;

endmodule
